// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared definitions for the sequential matrix-multiply controller:
//   - controller state encoding (IDLE / RUN / DONE)
//   - default matrix dimension and element width
//   - row-major element index helper (row*n + col)
package matmul_pkg;

    localparam int unsigned N_DEFAULT = 2;
    localparam int unsigned W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned rm_index(
        input int unsigned row,
        input int unsigned col,
        input int unsigned n
    );
        return row * n + col;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_mac.sv
// mac_unit
// Combinational multiply-accumulate shared by every step of the sequence.
//   a, b    : operand elements (unsigned, W bits)
//   acc_in  : running partial sum held by the controller
//   clr     : start a new dot product (ignore acc_in)
//   y       : (clr ? 0 : acc_in) + a*b, kept to the low W bits
module mac_unit
    import matmul_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc_in,
    input  logic         clr,
    output logic [W-1:0] y
);

    logic [W-1:0] base;

    assign base = clr ? '0 : acc_in;

    // W-bit context: product and sum both wrap modulo 2^W.
    assign y = base + a * b;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
// Computes C = A*B (N x N, unsigned W-bit, wrapping) with one shared MAC,
// one multiply-accumulate per clock, N^3 clocks per product.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   wr_en/wr_sel    : operand write strobe / target (0 = A, 1 = B), IDLE only
//   wr_addr/wr_data : row-major element index and value
//   start           : begin a product, IDLE only
//   busy            : high for the whole MAC sequence
//   done            : one-cycle completion pulse
//   rd_addr/rd_data : registered read port into C (out-of-range reads give 0)
//
// FSM states
//   state | meaning
//   IDLE  | operands writable, waiting for start
//   RUN   | stepping i/k/j counters, one MAC per clock
//   DONE  | C complete, single-cycle done pulse, then back to IDLE
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter  int unsigned N  = N_DEFAULT,
    parameter  int unsigned W  = W_DEFAULT,
    localparam int unsigned AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int unsigned   CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [AW:0]   ELEM_CNT = (AW + 1)'(N * N);

    state_t         state_q;
    state_t         state_d;
    logic           busy_d;
    logic           done_d;

    logic [CW-1:0]  cnt_i;
    logic [CW-1:0]  cnt_k;
    logic [CW-1:0]  cnt_j;
    logic           j_last;
    logic           k_last;
    logic           i_last;
    logic           last_mac;

    logic [AW-1:0]  a_idx;
    logic [AW-1:0]  b_idx;
    logic [AW-1:0]  c_idx;

    logic [W-1:0]   acc_q;
    logic [W-1:0]   mac_y;
    logic           mac_clr;

    logic           wr_ok;
    logic           rd_ok;

    logic [W-1:0]   mem_a [N*N];
    logic [W-1:0]   mem_b [N*N];
    logic [W-1:0]   mem_c [N*N];

    // ------------------------------------------------------------------
    // Loop bookkeeping: j innermost, then k, then i.
    // ------------------------------------------------------------------
    assign j_last   = (cnt_j == CNT_LAST);
    assign k_last   = (cnt_k == CNT_LAST);
    assign i_last   = (cnt_i == CNT_LAST);
    assign last_mac = j_last && k_last && i_last;

    assign a_idx = AW'(rm_index(32'(cnt_i), 32'(cnt_j), N));
    assign b_idx = AW'(rm_index(32'(cnt_j), 32'(cnt_k), N));
    assign c_idx = AW'(rm_index(32'(cnt_i), 32'(cnt_k), N));

    assign mac_clr = (cnt_j == '0);

    mac_unit #(
        .W (W)
    ) u_mac (
        .a      (mem_a[a_idx]),
        .b      (mem_b[b_idx]),
        .acc_in (acc_q),
        .clr    (mac_clr),
        .y      (mac_y)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_mac) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Decoded from the next state so busy/done leave a flop aligned
        // with the state register itself.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Counters and accumulator. Counters sit at zero outside RUN so every
    // run starts from element (0,0,0); after the last MAC they wrap to
    // zero naturally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || state_q != RUN) begin
            cnt_i <= '0;
            cnt_k <= '0;
            cnt_j <= '0;
        end else begin
            cnt_j <= j_last ? '0 : cnt_j + 1'b1;
            if (j_last) begin
                cnt_k <= k_last ? '0 : cnt_k + 1'b1;
                if (k_last) begin
                    cnt_i <= i_last ? '0 : cnt_i + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == RUN) begin
            acc_q <= mac_y;
        end
    end

    // ------------------------------------------------------------------
    // Operand and result storage (not reset). A write landing on the same
    // edge as start is seen by the first MAC one clock later.
    // ------------------------------------------------------------------
    assign wr_ok = ({1'b0, wr_addr} < ELEM_CNT);
    assign rd_ok = ({1'b0, rd_addr} < ELEM_CNT);

    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && wr_en && wr_ok && !wr_sel) begin
            mem_a[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && wr_en && wr_ok && wr_sel) begin
            mem_b[wr_addr] <= wr_data;
        end
    end

    // The final dot product lands on the same edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RUN && j_last) begin
            mem_c[c_idx] <= mac_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? mem_c[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Testbench for matmul_seq_ctrl: an N=2 instance and an N=3 instance share
// clock and reset. Expected C comes from constant tables or from a plain
// triple-loop matrix product over the operand values the bench wrote.
module tb_matmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en;
    logic [1:0]  wr_sel;
    logic [1:0]  start;
    logic [3:0]  wr_addr [2];
    logic [31:0] wr_data [2];
    logic [3:0]  rd_addr [2];

    logic        busy2, done2, busy3, done3;
    logic [31:0] rd_q2, rd_q3;

    int nerr = 0;
    int nchk = 0;

    logic [31:0] ma [2][9];
    logic [31:0] mb [2][9];
    logic [31:0] mc [2][9];

    typedef struct packed {
        logic [0:3][31:0] a;
        logic [0:3][31:0] b;
        logic [0:3][31:0] c;
    } vec_t;

    vec_t  tbl [3];
    string tbl_name [3];

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.N(2), .W(32)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en[0]),
        .wr_sel  (wr_sel[0]),
        .wr_addr (wr_addr[0][1:0]),
        .wr_data (wr_data[0]),
        .start   (start[0]),
        .busy    (busy2),
        .done    (done2),
        .rd_addr (rd_addr[0][1:0]),
        .rd_data (rd_q2)
    );

    matmul_seq_ctrl #(.N(3), .W(32)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en[1]),
        .wr_sel  (wr_sel[1]),
        .wr_addr (wr_addr[1]),
        .wr_data (wr_data[1]),
        .start   (start[1]),
        .busy    (busy3),
        .done    (done3),
        .rd_addr (rd_addr[1]),
        .rd_data (rd_q3)
    );

    function automatic int dim(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy2 : busy3;
    endfunction

    function automatic logic get_done(input int d);
        return (d == 0) ? done2 : done3;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? rd_q2 : rd_q3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // IDLE-time write; the model keeps only in-range addresses.
    task automatic wr(input int d, input logic sel, input int addr, input logic [31:0] data);
        wr_en[d]   = 1'b1;
        wr_sel[d]  = sel;
        wr_addr[d] = 4'(addr);
        wr_data[d] = data;
        tick();
        wr_en[d] = 1'b0;
        if (addr < dim(d) * dim(d)) begin
            if (sel) mb[d][addr] = data;
            else     ma[d][addr] = data;
        end
    endtask

    task automatic model_mul(input int d);
        int n;
        logic [31:0] s;
        n = dim(d);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < n; k++) begin
                s = 32'd0;
                for (int j = 0; j < n; j++) begin
                    s = s + ma[d][i*n+j] * mb[d][j*n+k];
                end
                mc[d][i*n+k] = s;
            end
        end
    endtask

    // Pulses start for one edge, expects done exactly N^3 edges later with
    // busy on every sample before it, then done dropping one edge after.
    task automatic run(input int d, input string tag);
        int n3;
        int lat;
        int nb;
        n3  = dim(d) * dim(d) * dim(d);
        lat = 0;
        nb  = 0;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        wr_en[d] = 1'b0;
        while (!get_done(d) && lat < 200) begin
            if (get_busy(d)) nb++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, n3);
        chk({tag, " busy_cycles"}, nb, n3);
        chk({tag, " busy_at_done"}, 32'(get_busy(d)), 32'd0);
        tick();
        chk({tag, " done_pulse_width"}, 32'(get_done(d)), 32'd0);
        model_mul(d);
    endtask

    task automatic check_c(input int d, input string tag);
        int n;
        n = dim(d);
        for (int e = 0; e < n * n; e++) begin
            rd_addr[d] = 4'(e);
            tick();
            chk($sformatf("%s C[%0d]", tag, e), get_rd(d), mc[d][e]);
        end
    endtask

    task automatic check_tbl_c(input int v, input string tag);
        for (int e = 0; e < 4; e++) begin
            rd_addr[0] = 4'(e);
            tick();
            chk($sformatf("%s C[%0d]", tag, e), rd_q2, tbl[v].c[e]);
        end
    endtask

    task automatic load_tbl(input int v);
        for (int e = 0; e < 4; e++) begin
            wr(0, 1'b0, e, tbl[v].a[e]);
            wr(0, 1'b1, e, tbl[v].b[e]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ndone;
        int first;
        logic [31:0] v;

        tbl[0].a = {32'd1, 32'd2, 32'd3, 32'd4};
        tbl[0].b = {32'd5, 32'd6, 32'd7, 32'd8};
        tbl[0].c = {32'd19, 32'd22, 32'd43, 32'd50};
        tbl_name[0] = "basic";
        tbl[1].a = {32'h8000_0000, 32'h8000_0000, 32'd3, 32'd4};
        tbl[1].b = {32'd1, 32'd1, 32'd1, 32'd1};
        tbl[1].c = {32'h0, 32'h0, 32'd7, 32'd7};
        tbl_name[1] = "wrap_sum";
        tbl[2].a = {32'hFFFF_FFFF, 32'd0, 32'd3, 32'd4};
        tbl[2].b = {32'd2, 32'd1, 32'd1, 32'd1};
        tbl[2].c = {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd10, 32'd7};
        tbl_name[2] = "wrap_prod";

        rst     = 1'b1;
        wr_en   = '0;
        wr_sel  = '0;
        start   = '0;
        for (int d = 0; d < 2; d++) begin
            wr_addr[d] = '0;
            wr_data[d] = '0;
            rd_addr[d] = '0;
        end
        repeat (3) tick();
        chk("reset busy2", 32'(busy2), 32'd0);
        chk("reset done2", 32'(done2), 32'd0);
        chk("reset rd2",   rd_q2,      32'd0);
        chk("reset busy3", 32'(busy3), 32'd0);
        chk("reset done3", 32'(done3), 32'd0);
        chk("reset rd3",   rd_q3,      32'd0);
        rst = 1'b0;
        tick();

        // Table-driven N=2 products.
        for (int t = 0; t < 3; t++) begin
            load_tbl(t);
            run(0, tbl_name[t]);
            check_tbl_c(t, tbl_name[t]);
        end

        // start and a write to A[0][0] in the middle of a run are dropped.
        load_tbl(0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        ndone = 0;
        first = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                start[0]   = 1'b1;
                wr_en[0]   = 1'b1;
                wr_sel[0]  = 1'b0;
                wr_addr[0] = 4'd0;
                wr_data[0] = 32'd100;
            end else begin
                start[0] = 1'b0;
                wr_en[0] = 1'b0;
            end
            tick();
            if (done2) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        chk("ignored done_count", ndone, 32'd1);
        chk("ignored done_edge", first, 32'd8);
        check_tbl_c(0, "ignored");
        run(0, "after_ignored");
        check_tbl_c(0, "after_ignored");

        // Reset at RUN cycle 4 abandons the run with no done pulse.
        rd_addr[0] = 4'd0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst busy", 32'(busy2), 32'd0);
        chk("midrst done", 32'(done2), 32'd0);
        chk("midrst rd",   rd_q2,      32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done2 || busy2) ndone++;
        end
        chk("midrst no_activity", ndone, 32'd0);
        run(0, "restart");
        check_tbl_c(0, "restart");

        // Write to B[1][1] on the same edge as start is used by that run.
        wr_en[0]   = 1'b1;
        wr_sel[0]  = 1'b1;
        wr_addr[0] = 4'd3;
        wr_data[0] = 32'd9;
        mb[0][3]   = 32'd9;
        run(0, "same_edge");
        for (int e = 0; e < 4; e++) begin
            rd_addr[0] = 4'(e);
            tick();
            case (e)
                0: chk("same_edge C00", rd_q2, 32'd19);
                1: chk("same_edge C01", rd_q2, 32'd24);
                2: chk("same_edge C10", rd_q2, 32'd43);
                default: chk("same_edge C11", rd_q2, 32'd54);
            endcase
        end

        // N=3: identity B, back-to-back runs at the earliest legal edge.
        for (int e = 0; e < 9; e++) begin
            wr(1, 1'b0, e, 32'h0101_0101 * (e + 1) + 32'd7);
            wr(1, 1'b1, e, (e % 4 == 0) ? 32'd1 : 32'd0);
        end
        run(1, "b2b_first");
        run(1, "b2b_second");
        for (int e = 0; e < 9; e++) begin
            rd_addr[1] = 4'(e);
            tick();
            chk($sformatf("identity C[%0d]", e), rd_q3, ma[1][e]);
        end
        rd_addr[1] = 4'd9;
        tick();
        chk("oob rd 9", rd_q3, 32'd0);
        rd_addr[1] = 4'd15;
        tick();
        chk("oob rd 15", rd_q3, 32'd0);

        // Random operands against the matrix-product model.
        for (int r = 0; r < 8; r++) begin
            int d;
            int n;
            d = r % 2;
            n = dim(d);
            for (int e = 0; e < n * n; e++) begin
                v = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 15));
                wr(d, 1'b0, e, v);
                v = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 15));
                wr(d, 1'b1, e, v);
            end
            if (d == 1) begin
                for (int x = 0; x < 3; x++) begin
                    wr(1, 1'($urandom_range(0, 1)), int'($urandom_range(9, 15)), $urandom());
                end
            end
            run(d, $sformatf("rand%0d", r));
            check_c(d, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencing controller for the matrix-multiply datapath. It holds operand matrices A and B (N×N, W-bit) loaded over a simple write port and computes C = A·B on a single shared multiply-accumulate unit, one MAC per clock. It raises a done pulse when finished and exposes C through a registered read port. It replaces the fully-parallel N³-multiplier array wherever area matters more than latency.

## Interface
- N, 2, matrix dimension; legal range N ≥ 2.
- W, 32, element and result width in bits.
- AW, $clog2(N*N), element address width. Derived; not to be overridden.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  operand write strobe; honoured only in IDLE.
- wr_sel  input  1  write target: 0 = A, 1 = B.
- wr_addr  input  AW  row-major element index (row*N + col).
- wr_data  input  W  operand value.
- start  input  1  begin computation; honoured only in IDLE.
- busy  output  1  high while the MAC sequence runs.
- done  output  1  one-cycle completion pulse.
- rd_addr  input  AW  row-major index into C.
- rd_data  output  W  C[rd_addr], registered.

## Operation
- **Clock and reset.** One clock, `clk`. Reset `rst` is synchronous and active-high.
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN when start = 1.
  - RUN → DONE after the last MAC.
  - DONE → IDLE unconditionally after one cycle.
- **Outputs by state.**
  - busy = 1 exactly in RUN.
  - done = 1 exactly in DONE.
  - Both are registered state decodes, with no combinational path from inputs.
- **Counters.**
  - i (row of A), k (column of B), j (inner index), each 0..N-1.
  - Nesting: j innermost, then k, then i outermost.
  - All counters are zero on entry to RUN.
- **Each RUN cycle:**
  - acc_next = (j == 0 ? 0 : acc) + (A[i][j] * B[j][k]).
  - acc <= acc_next.
  - When j == N-1, C[i][k] <= acc_next.
- **Arithmetic.**
  - Unsigned.
  - Product truncated to the low W bits.
  - Sum wraps modulo 2^W.
  - No saturation or overflow flag.
- **Run length.** RUN lasts exactly N³ cycles. The transition to DONE coincides with the write of C[N-1][N-1].
- **Writes.**
  - In IDLE, wr_en writes A or B (selected by wr_sel) at the clock edge.
  - wr_en in RUN or DONE is ignored.
  - wr_addr ≥ N*N is ignored.
- **Simultaneous start and wr_en in IDLE.** The write lands on the same edge, and RUN uses the new value.
- **start outside IDLE** is ignored; it is not queued.
- **Reads.**
  - rd_data <= C[rd_addr] every cycle, in any state.
  - rd_addr ≥ N*N yields 0.
  - Reading during RUN returns the previous result for entries not yet rewritten.
- **Reset.**
  - Forces IDLE, clears the counters, acc, busy, done and rd_data.
  - Does not clear A, B or C.
  - Reset mid-RUN abandons the computation with no done pulse; a partially updated C is permitted.

## Timing
- **Reset values:** busy = 0, done = 0, rd_data = 0.
- **start sampled at edge t:**
  - busy = 1 from t through t+N³.
  - done = 1 for the single cycle t+N³ .. t+N³+1.
  - Earliest next honoured start is at edge t+N³+2.
- **Latency:** start to done is N³+1 cycles. For N = 2 this is 9.
- **Read latency:** one cycle from rd_addr to rd_data.
- **C availability:** all of C is final and readable by the done cycle, so a read issued at the done edge returns final data.
- **Write latency:** a write issued at edge t is visible to a RUN beginning at edge t+1.

## Structure
- **Package `matmul_pkg`:**
  - State enum (IDLE, RUN, DONE).
  - Default N and W constants.
  - Function for the row-major index (row*N + col).
- **Sub-module `mac_unit`** (combinational):
  - Inputs a, b, acc_in, clr.
  - Output y = (clr ? 0 : acc_in) + a*b, truncated to W bits.
  - The controller owns the acc register.
- **Top level** holds the operand arrays A, B and C, the FSM, the counters and the read register.

## Test plan
- **Basic multiply.** N=2; A={1,2,3,4}, B={5,6,7,8} written; start.
  - Expect busy for 8 cycles, done on cycle 9.
  - C reads {19,22,43,50}.
- **Wrap-around.** A[0][0]=A[0][1]=0x8000_0000, B all 1.
  - Expect C[0][0] = 0x0000_0000.
  - Then A[0][0]=0xFFFF_FFFF, B[0][0]=2, other A[0][*]=0 gives C[0][0] = 0xFFFF_FFFE.
- **Ignored inputs during RUN.** Issue start and wr_en (A[0][0]=100) mid-RUN.
  - Expect exactly one done, 9 cycles after the original start.
  - C unchanged from the basic case.
  - A[0][0] still 1 on a following run.
- **Reset mid-run.** Assert rst at RUN cycle 4.
  - busy and done go to 0 next cycle; no done pulse appears.
  - A restarted run gives the correct C={19,22,43,50}.
- **Same-edge write and start.** Write B[1][1]=9 on the same edge as start.
  - Expect C[0][1]=2·9+... per the new B (C[1][1]=4·9+3·6=54).
- **Back-to-back runs and out-of-range read.** Second start at the first legal edge after done with N=3 and identity B.
  - C equals A; done arrives 28 cycles after start.
  - rd_addr=9 returns 0.
